ped_crossing_ctrl: RTL and testbench

- Self-timed pedestrian crossing controller. It replaces the purely combinational walk/hand decode with a sequenced crossing: request latch, grant handshake with the vehicle-phase controller, a timed WALK interval, then a flashing-hand CLEAR interval with a two-digit seven-segment countdown.
- Sits between the push-button input, the intersection master controller and the crosswalk signal heads.
- Interval lengths and tick rate are parameters; the block owns its prescaler and second counters, so there is no external master timer.

---
 rtl/ped_crossing_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Self-timed pedestrian crossing: request latch, grant handshake with the master,
// timed WALK, then flashing-hand CLEAR with a two-digit seven-segment countdown.

module seven_segment (
    input  logic [3:0] i_bin,
    output logic [6:0] o_seg
);
    // Segments {g,f,e,d,c,b,a}, active high
    always_comb begin
        case (i_bin)
            4'd0:    o_seg = 7'b0111111;
            4'd1:    o_seg = 7'b0000110;
            4'd2:    o_seg = 7'b1011011;
            4'd3:    o_seg = 7'b1001111;
            4'd4:    o_seg = 7'b1100110;
            4'd5:    o_seg = 7'b1101101;
            4'd6:    o_seg = 7'b1111101;
            4'd7:    o_seg = 7'b0000111;
            4'd8:    o_seg = 7'b1111111;
            4'd9:    o_seg = 7'b1101111;
            default: o_seg = 7'b0000000;
        endcase
    end
endmodule

module ped_crossing_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int WALK_SEC  = 7,
    parameter int CLEAR_SEC = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ped_request,
    input  logic       ped_enable,
    output logic       walk_active,
    output logic       ped_done,
    output logic       req_pending,
    output logic       hand_light,
    output logic       walk_light,
    output logic [6:0] tens_digit,
    output logic [6:0] ones_digit
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WALK,
        S_CLEAR
    } state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [PW-1:0] r_presc;
    logic [6:0]    r_sec;
    logic          r_req;
    logic          w_tick, w_last, w_timed, w_load_walk, w_load_clear;
    logic [3:0]    w_tens_bin, w_ones_bin;
    logic [6:0]    w_tens_seg, w_ones_seg;
    logic          r_walk_active, r_ped_done, r_hand, r_walk;
    logic [6:0]    r_tens, r_ones;

    // Reset asserts immediately, releases two clk edges after reset_n rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_tick  = (r_presc == PW'(TICK_DIV - 1));
    assign w_last  = w_tick && (r_sec == 7'd1);
    assign w_timed = (r_state == S_WALK) || (r_state == S_CLEAR);

    always_comb begin
        w_next       = r_state;
        w_load_walk  = 1'b0;
        w_load_clear = 1'b0;
        case (r_state)
            S_IDLE:  if (r_req || ped_request) w_next = S_WAIT;
            S_WAIT: begin
                if (ped_enable) begin
                    w_next      = S_WALK;
                    w_load_walk = 1'b1;
                end
            end
            // A revoked grant cuts WALK short; CLEAR always runs its full length
            S_WALK: begin
                if (!ped_enable || w_last) begin
                    w_next       = S_CLEAR;
                    w_load_clear = 1'b1;
                end
            end
            S_CLEAR: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_presc <= '0;
            r_sec   <= 7'd0;
        end else if (w_load_walk) begin
            r_presc <= '0;
            r_sec   <= 7'(WALK_SEC);
        end else if (w_load_clear) begin
            r_presc <= '0;
            r_sec   <= 7'(CLEAR_SEC);
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_timed && w_tick && (r_sec > 7'd1)) r_sec <= r_sec - 7'd1;
        end
    end

    // Taking the grant absorbs any press arriving on the same cycle
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                             r_req <= 1'b0;
        else if ((r_state == S_WAIT) && ped_enable) r_req <= 1'b0;
        else if (ped_request)                     r_req <= 1'b1;
    end

    assign w_tens_bin = 4'(r_sec / 7'd10);
    assign w_ones_bin = 4'(r_sec % 7'd10);

    seven_segment u_tens_dec (.i_bin(w_tens_bin), .o_seg(w_tens_seg));
    seven_segment u_ones_dec (.i_bin(w_ones_bin), .o_seg(w_ones_seg));

    // Heads and display are registered off the current state; ped_done marks the
    // first IDLE cycle after an active crossing
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_walk_active <= 1'b0;
            r_ped_done    <= 1'b0;
            r_hand        <= 1'b1;
            r_walk        <= 1'b0;
            r_tens        <= 7'd0;
            r_ones        <= 7'd0;
        end else begin
            r_walk_active <= w_timed;
            r_ped_done    <= (r_state == S_IDLE) && r_walk_active;
            r_walk        <= (r_state == S_WALK);
            r_tens        <= 7'd0;
            r_ones        <= 7'd0;
            r_hand        <= (r_state != S_WALK);
            if (r_state == S_CLEAR) begin
                r_hand <= (r_presc < PW'(TICK_DIV / 2));
                r_ones <= w_ones_seg;
                if (r_sec >= 7'd10) r_tens <= w_tens_seg;
            end
        end
    end

    assign walk_active = r_walk_active;
    assign ped_done    = r_ped_done;
    assign req_pending = r_req;
    assign hand_light  = r_hand;
    assign walk_light  = r_walk;
    assign tens_digit  = r_tens;
    assign ones_digit  = r_ones;
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: elapsed-cycle crossing model checked every cycle,
// plus directed scenarios with hand-computed counts and digit codes.

module tb_ped_crossing_ctrl;
    localparam int TD = 4;
    localparam int WS = 3;
    localparam int CS = 12;

    logic       clk = 1'b0;
    logic       reset_n, ped_request, ped_enable;
    logic       walk_active, ped_done, req_pending, hand_light, walk_light;
    logic [6:0] tens_digit, ones_digit;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ped_crossing_ctrl #(.TICK_DIV(TD), .WALK_SEC(WS), .CLEAR_SEC(CS)) dut (
        .clk(clk), .reset_n(reset_n), .ped_request(ped_request), .ped_enable(ped_enable),
        .walk_active(walk_active), .ped_done(ped_done), .req_pending(req_pending),
        .hand_light(hand_light), .walk_light(walk_light),
        .tens_digit(tens_digit), .ones_digit(ones_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Model: mode plus cycles elapsed in that mode; outputs show the previous cycle's mode
    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_WALK, M_CLEAR} mmode_t;
    mmode_t     m_mode, n_mode;
    int         m_n, n_n;
    logic       m_pend, n_pend, m_fin, n_fin;
    logic       x_wa, x_walk, x_hand;
    logic [6:0] x_tens, x_ones;
    logic       e_wa, e_walk, e_hand, e_done, e_req;
    logic [6:0] e_tens, e_ones;

    always_comb begin
        int sec;
        sec    = CS - m_n / TD;
        n_mode = m_mode;
        n_n    = m_n + 1;
        n_fin  = 1'b0;
        case (m_mode)
            M_IDLE:  if (m_pend || ped_request) begin n_mode = M_WAIT; n_n = 0; end
            M_WAIT:  if (ped_enable) begin n_mode = M_WALK; n_n = 0; end
            M_WALK:  if (!ped_enable || m_n == WS * TD - 1) begin n_mode = M_CLEAR; n_n = 0; end
            default: if (m_n == CS * TD - 1) begin n_mode = M_IDLE; n_n = 0; n_fin = 1'b1; end
        endcase
        n_pend = ((m_mode == M_WAIT) && ped_enable) ? 1'b0 : (m_pend || ped_request);
        x_wa   = (m_mode == M_WALK) || (m_mode == M_CLEAR);
        x_walk = (m_mode == M_WALK);
        x_hand = (m_mode == M_CLEAR) ? ((m_n % TD) < TD / 2) : (m_mode != M_WALK);
        x_tens = (m_mode == M_CLEAR && sec >= 10) ? seg(sec / 10) : 7'd0;
        x_ones = (m_mode == M_CLEAR) ? seg(sec % 10) : 7'd0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= M_IDLE; m_n <= 0; m_pend <= 1'b0; m_fin <= 1'b0;
            e_wa <= 1'b0; e_walk <= 1'b0; e_hand <= 1'b1; e_done <= 1'b0; e_req <= 1'b0;
            e_tens <= 7'd0; e_ones <= 7'd0;
        end else begin
            m_mode <= n_mode; m_n <= n_n; m_pend <= n_pend; m_fin <= n_fin;
            e_wa <= x_wa; e_walk <= x_walk; e_hand <= x_hand; e_done <= m_fin; e_req <= n_pend;
            e_tens <= x_tens; e_ones <= x_ones;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_walk_active", walk_active, e_wa);
            chk("cyc_walk_light", walk_light, e_walk);
            chk("cyc_hand_light", hand_light, e_hand);
            chk("cyc_ped_done", ped_done, e_done);
            chk("cyc_req_pending", req_pending, e_req);
            chk("cyc_tens", tens_digit, e_tens);
            chk("cyc_ones", ones_digit, e_ones);
        end
    end

    int         walk_cnt, clear_cnt, done_cnt, toggles, gap;
    logic [6:0] f_ones, f_tens, c9_ones, c9_tens, l_ones, l_tens;
    logic       req_end, prev_hand;
    bit         seen_done, gap_done;

    // Samples one crossing; optionally drops the grant in WALK / presses in CLEAR
    task automatic observe(input int ncyc, input int walk_drop, input int press_at);
        walk_cnt = 0; clear_cnt = 0; done_cnt = 0; toggles = 0; gap = 0;
        seen_done = 1'b0; gap_done = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            ped_request = 1'b0;
            if (walk_light && !seen_done) begin
                walk_cnt++;
                if (walk_cnt == walk_drop) ped_enable = 1'b0;
            end
            if (walk_active && !walk_light && !seen_done) begin
                if (clear_cnt == 0) begin
                    f_ones = ones_digit; f_tens = tens_digit;
                end else if (hand_light != prev_hand) toggles++;
                if (clear_cnt == 12) begin c9_ones = ones_digit; c9_tens = tens_digit; end
                if (walk_drop > 0 && clear_cnt == 1) ped_enable = 1'b1;
                if (walk_drop > 0 && clear_cnt == 10) ped_enable = 1'b0;
                if (clear_cnt == press_at) ped_request = 1'b1;
                l_ones = ones_digit; l_tens = tens_digit; req_end = req_pending;
                prev_hand = hand_light;
                clear_cnt++;
            end
            if (seen_done && !gap_done) begin
                if (walk_light) gap_done = 1'b1;
                else gap++;
            end
            if (ped_done) begin done_cnt++; seen_done = 1'b1; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, wa_cnt, cc;
        reset_n = 1'b1; ped_request = 1'b0; ped_enable = 1'b0;
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: idle
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (hand_light !== 1'b1 || walk_light !== 1'b0 || tens_digit !== 7'd0 ||
                ones_digit !== 7'd0 || walk_active !== 1'b0 || ped_done !== 1'b0) bad++;
        end
        chk("t1_idle_outputs", bad, 0);
        chk("t1_req_idle", req_pending, 0);

        // 2: full crossing with grant held
        ped_enable = 1'b1; ped_request = 1'b1;
        @(negedge clk);
        ped_request = 1'b0;
        chk("t2_req_latched", req_pending, 1);
        observe(110, 0, -1);
        chk("t2_walk_cycles", walk_cnt, 12);
        chk("t2_clear_cycles", clear_cnt, 48);
        chk("t2_first_ones", f_ones, 7'b1011011);
        chk("t2_first_tens", f_tens, 7'b0000110);
        chk("t2_nine_tens_blank", c9_tens, 7'b0000000);
        chk("t2_nine_ones", c9_ones, 7'b1101111);
        chk("t2_last_ones", l_ones, 7'b0000110);
        chk("t2_last_tens", l_tens, 7'b0000000);
        chk("t2_hand_toggles", toggles, 23);
        chk("t2_done_pulses", done_cnt, 1);

        // 3: request held in WAIT until grant
        ped_enable = 1'b0; ped_request = 1'b1;
        @(negedge clk);
        ped_request = 1'b0;
        wa_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (walk_active) wa_cnt++;
        end
        chk("t3_wait_no_walk", wa_cnt, 0);
        chk("t3_req_still", req_pending, 1);
        ped_enable = 1'b1;
        @(negedge clk);
        chk("t3_walk_edge1", walk_light, 0);
        @(negedge clk);
        chk("t3_walk_edge2", walk_light, 1);
        observe(80, 0, -1);
        chk("t3_done_pulses", done_cnt, 1);

        // 4: grant revoked at WALK cycle 5, toggled again inside CLEAR
        ped_request = 1'b1;
        @(negedge clk);
        ped_request = 1'b0;
        observe(110, 5, -1);
        chk("t4_walk_cycles", walk_cnt, 6);
        chk("t4_clear_cycles", clear_cnt, 48);
        chk("t4_first_ones", f_ones, 7'b1011011);
        chk("t4_first_tens", f_tens, 7'b0000110);
        chk("t4_done_pulses", done_cnt, 1);

        // 5: press during CLEAR queues the next crossing
        ped_enable = 1'b1; ped_request = 1'b1;
        @(negedge clk);
        ped_request = 1'b0;
        observe(80, 0, 20);
        chk("t5_done_pulses", done_cnt, 1);
        chk("t5_req_end_clear", req_end, 1);
        chk("t5_idle_gap", gap, 1);
        chk("t5_second_walk", gap_done, 1);
        observe(80, 0, -1);
        chk("t5_second_done", done_cnt, 1);

        // 6: asynchronous reset mid-CLEAR drops a pending request
        ped_request = 1'b1;
        @(negedge clk);
        ped_request = 1'b0;
        cc = 0;
        for (int i = 0; i < 100 && cc < 10; i++) begin
            @(negedge clk);
            if (walk_active && !walk_light) cc++;
        end
        chk("t6_reached_clear", cc, 10);
        ped_request = 1'b1;
        @(negedge clk);
        ped_request = 1'b0;
        chk("t6_req_before", req_pending, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_walk_active", walk_active, 0);
        chk("t6_rst_ped_done", ped_done, 0);
        chk("t6_rst_req", req_pending, 0);
        chk("t6_rst_hand", hand_light, 1);
        chk("t6_rst_walk", walk_light, 0);
        chk("t6_rst_tens", tens_digit, 7'd0);
        chk("t6_rst_ones", ones_digit, 7'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_req_lost", req_pending, 0);
        chk("t6_stays_idle", walk_active, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
